bf_mem_arbiter: RTL and testbench
=================================

# bf_mem_arbiter

Shares one single-port program/data SRAM and the character I/O channels between two requesters:
- the BF core's bus-request port, after the serial bus has been deserialized;
- a host debug/loader port.

Each accepted request runs to completion before the next grant. The block sits between the core-side bus logic and the physical memory/I/O on the host FPGA side of the chip bus.

## Interface
Parameters:
- ADDR_WIDTH, 16, request address width (program and data spaces).
- DATA_WIDTH, 8, memory/char width.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- core_req_valid  in  1  core request pending.
- core_req_op  in  3  bus op: 010 prog read, 100 data read, 101 data write, 110 input read, 111 output write; others illegal.
- core_req_addr  in  ADDR_WIDTH  address.
- core_req_wdata  in  DATA_WIDTH  write/output data.
- core_req_ready  out  1  one-cycle accept pulse.
- core_resp_valid  out  1  one-cycle completion pulse.
- core_resp_data  out  DATA_WIDTH  read result; 0 for writes and illegal ops.
- host_req_valid / host_req_write / host_req_region  in  1 each  request, write enable, region (0 prog, 1 data).
- host_req_addr  in  ADDR_WIDTH; host_req_wdata  in  DATA_WIDTH.
- host_req_ready / host_resp_valid  out  1; host_resp_data  out  DATA_WIDTH.
- mem_en, mem_we  out  1; mem_addr  out  ADDR_WIDTH+1  address as {region, addr}; mem_wdata  out  DATA_WIDTH.
- mem_rdata  in  DATA_WIDTH  synchronous read, valid the cycle after mem_en.
- out_valid  out  1; out_data  out  DATA_WIDTH; out_ready  in  1.
- in_valid  in  1; in_data  in  DATA_WIDTH; in_ready  out  1.
- busy  out  1  state != IDLE.
- err  out  1  sticky; set when an illegal core op is accepted; cleared only by reset.

## Operation
Latched transaction registers: owner, op, region, addr, wdata, resp_data.

FSM states and transitions:
- **IDLE:** if any valid, pick winner (see Configuration), pulse its req_ready, latch request. Next state:
  - MEM for memory ops;
  - OUT for op 111;
  - IN for op 110;
  - ERR for illegal ops.
  - Host ops are always memory ops.
  - Core region: 0 for op 010, 1 for ops 100/101.
- **MEM:** mem_en=1; mem_we=1 for writes; mem_addr/mem_wdata driven from latches. Next: CAP.
- **CAP:** resp_data <= mem_rdata for reads, 0 for writes. Next: RESP.
- **OUT:** out_valid=1, out_data=wdata. On out_ready, next RESP with resp_data=0; otherwise hold.
- **IN:** in_ready=1. On in_valid, resp_data <= in_data and next RESP; otherwise hold.
- **ERR:** err <= 1, resp_data <= 0. Next: RESP.
- **RESP:** pulse owner's resp_valid with resp_data. Next: IDLE.

Combinational outputs and reset values:
- All strobes/valids/readies are decoded combinationally from state. They are 0 outside their state and 0 at reset.
- mem_addr, mem_wdata, out_data are 0 when not driven.
- resp_data outputs are 0 except in RESP.
- The idle requester's ready/resp stay 0 throughout another's transaction.

Boundary rules:
- Requests must stay valid and stable until their ready pulse; the block never accepts without a grant.
- Reset mid-transaction: return to IDLE with no response pulse. The memory write is not issued if reset lands before MEM. An in_data word is consumed only on an in_valid && in_ready cycle.
- Address wrap is caller's responsibility; addresses are passed unchanged.

## Timing
Cycle numbers are relative to the accept cycle (cycle 0):
- **Memory op:** mem_en in cycle 1, resp_valid in cycle 3. Next grant is possible in cycle 4.
- **Output:** resp_valid one cycle after the out_ready handshake cycle.
- **Input:** resp_valid one cycle after the in_valid handshake cycle.
- **Illegal op:** err set at the end of cycle 1, resp_valid in cycle 2.

## Configuration
BF_ARB_ROUND_ROBIN_EN:
- **Defined:** on simultaneous valids, grant the requester not served last. A last_owner register resets to host, so the core wins the first tie. A lone valid is always granted.
- **Undefined:** fixed priority, host always wins ties; last_owner is not implemented.

## Test plan
- Host writes data[5]=0x2A, then core op 100 addr 5 → mem_addr=0x10005; core_resp_data=0x2A in cycle 3.
- Core op 010 addr 0x0003 with prog[3]=0x2B ('+') → mem_addr=0x00003, mem_we=0; response 0x2B.
- Core op 111 wdata 0x41 with out_ready low for 5 cycles → out_valid held 5 cycles with out_data 0x41; resp_valid one cycle after out_ready rises.
- Both requesters valid every IDLE, 4 transactions:
  - macro defined → grants core, host, core, host;
  - undefined → all host.
- Core op 001 → ready pulse, resp_valid in cycle 2 with data 0, err=1 and stays 1; then reset clears it.
- Reset asserted in IN state with in_valid low → in_ready 0 next cycle, busy 0, no resp_valid; a later in_valid is not consumed.

Source files
------------

// File: rtl/bf_mem_arbiter_if.sv
// bf_mem_arbiter_if: request, response, memory and character-I/O signals
// shared between the arbiter (slave modport) and its surroundings
// (master modport).
//
// Handshake semantics: a requester raises *_req_valid with stable fields
// and holds them until the one-cycle *_req_ready pulse, which is the accept.
// *_resp_valid is a one-cycle completion pulse with no back-pressure.
// out_valid/out_ready and in_valid/in_ready transfer a word only on a cycle
// where both are high.
interface bf_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    // core bus-request port
    logic                  core_req_valid;
    logic [2:0]            core_req_op;
    logic [ADDR_WIDTH-1:0] core_req_addr;
    logic [DATA_WIDTH-1:0] core_req_wdata;
    logic                  core_req_ready;
    logic                  core_resp_valid;
    logic [DATA_WIDTH-1:0] core_resp_data;

    // host debug/loader port
    logic                  host_req_valid;
    logic                  host_req_write;
    logic                  host_req_region;
    logic [ADDR_WIDTH-1:0] host_req_addr;
    logic [DATA_WIDTH-1:0] host_req_wdata;
    logic                  host_req_ready;
    logic                  host_resp_valid;
    logic [DATA_WIDTH-1:0] host_resp_data;

    // single-port SRAM
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH:0]   mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // character output / input channels
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    // status and debug
    logic                  busy;
    logic                  err;
    logic [2:0]            fsm_state;

    modport slave (
        input  core_req_valid, core_req_op, core_req_addr, core_req_wdata,
        input  host_req_valid, host_req_write, host_req_region,
        input  host_req_addr, host_req_wdata,
        input  mem_rdata, out_ready, in_valid, in_data,
        output core_req_ready, core_resp_valid, core_resp_data,
        output host_req_ready, host_resp_valid, host_resp_data,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output out_valid, out_data, in_ready,
        output busy, err, fsm_state
    );

    modport master (
        output core_req_valid, core_req_op, core_req_addr, core_req_wdata,
        output host_req_valid, host_req_write, host_req_region,
        output host_req_addr, host_req_wdata,
        output mem_rdata, out_ready, in_valid, in_data,
        input  core_req_ready, core_resp_valid, core_resp_data,
        input  host_req_ready, host_resp_valid, host_resp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  out_valid, out_data, in_ready,
        input  busy, err, fsm_state
    );
endinterface

// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter: shares one single-port program/data SRAM and the character
// I/O channels between the BF core bus port and a host debug/loader port.
// One transaction runs to completion before the next grant.
//
// Optional feature macro: BF_ARB_ROUND_ROBIN_EN
//   defined   -> ties go to the requester not served last (core wins the
//                first tie after reset)
//   undefined -> fixed priority, host wins every tie
module bf_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clock,
    input  logic            reset,
    bf_mem_arbiter_if.slave bus
);

    localparam logic [2:0] OP_PROG_RD = 3'b010;
    localparam logic [2:0] OP_DATA_RD = 3'b100;
    localparam logic [2:0] OP_DATA_WR = 3'b101;
    localparam logic [2:0] OP_IN_RD   = 3'b110;
    localparam logic [2:0] OP_OUT_WR  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MEM  = 3'd1,
        S_CAP  = 3'd2,
        S_OUT  = 3'd3,
        S_IN   = 3'd4,
        S_ERR  = 3'd5,
        S_RESP = 3'd6
    } state_t;

    state_t                state;

    // Latched transaction. The op's kind is carried by the state it sends
    // the FSM to, plus write_q for memory ops, so the raw op is not kept.
    logic                  owner_host;
    logic                  write_q;
    logic                  region_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] resp_q;
    logic                  err_q;

    logic                  grant_core;
    logic                  grant_host;

    state_t                core_next;
    logic                  core_region;
    logic                  core_write;

`ifdef BF_ARB_ROUND_ROBIN_EN
    // High when the host owned the most recent grant.
    logic                  last_host;
`endif

    // Decode the core op into its destination state, memory region and write flag.
    always_comb begin
        core_next   = S_ERR;
        core_region = 1'b0;
        core_write  = 1'b0;
        case (bus.core_req_op)
            OP_PROG_RD: begin
                core_next = S_MEM;
            end
            OP_DATA_RD: begin
                core_next   = S_MEM;
                core_region = 1'b1;
            end
            OP_DATA_WR: begin
                core_next   = S_MEM;
                core_region = 1'b1;
                core_write  = 1'b1;
            end
            OP_IN_RD:  core_next = S_IN;
            OP_OUT_WR: core_next = S_OUT;
            default:   core_next = S_ERR;
        endcase
    end

`ifdef BF_ARB_ROUND_ROBIN_EN
    // Round-robin grant: a tie goes to whoever was not served last.
    always_comb begin
        grant_core = 1'b0;
        grant_host = 1'b0;
        if (state == S_IDLE) begin
            if (bus.core_req_valid && bus.host_req_valid) begin
                if (last_host) begin
                    grant_core = 1'b1;
                end else begin
                    grant_host = 1'b1;
                end
            end else if (bus.core_req_valid) begin
                grant_core = 1'b1;
            end else if (bus.host_req_valid) begin
                grant_host = 1'b1;
            end
        end
    end
`else
    // Fixed-priority grant: the host wins every tie.
    always_comb begin
        grant_core = 1'b0;
        grant_host = 1'b0;
        if (state == S_IDLE) begin
            if (bus.host_req_valid) begin
                grant_host = 1'b1;
            end else if (bus.core_req_valid) begin
                grant_core = 1'b1;
            end
        end
    end
`endif

    // Transaction FSM: accept and latch in IDLE, then run the op to its response.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            owner_host <= 1'b0;
            write_q    <= 1'b0;
            region_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
`ifdef BF_ARB_ROUND_ROBIN_EN
            last_host  <= 1'b1;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_host) begin
                        owner_host <= 1'b1;
                        write_q    <= bus.host_req_write;
                        region_q   <= bus.host_req_region;
                        addr_q     <= bus.host_req_addr;
                        wdata_q    <= bus.host_req_wdata;
                        state      <= S_MEM;
`ifdef BF_ARB_ROUND_ROBIN_EN
                        last_host  <= 1'b1;
`endif
                    end else if (grant_core) begin
                        owner_host <= 1'b0;
                        write_q    <= core_write;
                        region_q   <= core_region;
                        addr_q     <= bus.core_req_addr;
                        wdata_q    <= bus.core_req_wdata;
                        state      <= core_next;
`ifdef BF_ARB_ROUND_ROBIN_EN
                        last_host  <= 1'b0;
`endif
                    end
                end
                S_MEM: begin
                    state <= S_CAP;
                end
                S_CAP: begin
                    // Read data arrives the cycle after mem_en.
                    resp_q <= write_q ? '0 : bus.mem_rdata;
                    state  <= S_RESP;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        resp_q <= '0;
                        state  <= S_RESP;
                    end
                end
                S_IN: begin
                    if (bus.in_valid) begin
                        resp_q <= bus.in_data;
                        state  <= S_RESP;
                    end
                end
                S_ERR: begin
                    err_q  <= 1'b1;
                    resp_q <= '0;
                    state  <= S_RESP;
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Accept pulses come straight from the grant, which is only live in IDLE.
    assign bus.core_req_ready  = grant_core;
    assign bus.host_req_ready  = grant_host;

    // Responses go only to the owner, and only in RESP.
    assign bus.core_resp_valid = (state == S_RESP) && !owner_host;
    assign bus.host_resp_valid = (state == S_RESP) && owner_host;
    assign bus.core_resp_data  = bus.core_resp_valid ? resp_q : '0;
    assign bus.host_resp_data  = bus.host_resp_valid ? resp_q : '0;

    // Memory strobes and buses are held at zero outside MEM.
    assign bus.mem_en          = (state == S_MEM);
    assign bus.mem_we          = (state == S_MEM) && write_q;
    assign bus.mem_addr        = (state == S_MEM) ? {region_q, addr_q} : '0;
    assign bus.mem_wdata       = (state == S_MEM) ? wdata_q : '0;

    // Character channels.
    assign bus.out_valid       = (state == S_OUT);
    assign bus.out_data        = (state == S_OUT) ? wdata_q : '0;
    assign bus.in_ready        = (state == S_IN);

    // Status.
    assign bus.busy            = (state != S_IDLE);
    assign bus.err             = err_q;
    assign bus.fsm_state       = state;

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// tb_bf_mem_arbiter: directed vector table, tie arbitration, error and reset
// sequences, then randomized transactions checked against a reference model.
module tb_bf_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;

    // clock / reset
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bf_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    bf_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // SRAM environment: synchronous read, data valid the cycle after mem_en.
    logic [7:0] sram [0:131071];
    always @(posedge clock) begin
        logic [7:0] rd;
        if (bus.mem_en) begin
            rd = sram[bus.mem_addr];
            if (bus.mem_we) sram[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata <= rd;
        end
    end

    // scoreboard counters
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: memory as a sparse map, sticky error, last grant owner.
    logic [7:0] ref_mem [int];
    bit         model_err;
    bit         model_last_host;

    task automatic model_txn(input bit is_host, input logic [2:0] op, input bit hw, input bit hr,
                             input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] in_word,
                             input int io_delay, output logic [7:0] d, output int lat,
                             output bit is_mem, output logic [16:0] maddr, output bit we);
        bit rgn;
        int key;
        model_last_host = is_host;
        d = 8'h00; lat = 3; is_mem = 1'b0; maddr = '0; we = 1'b0; rgn = 1'b0;
        if (is_host) begin
            is_mem = 1'b1; we = hw; rgn = hr;
        end else begin
            case (op)
                3'b010: begin is_mem = 1'b1; rgn = 1'b0; end
                3'b100: begin is_mem = 1'b1; rgn = 1'b1; end
                3'b101: begin is_mem = 1'b1; rgn = 1'b1; we = 1'b1; end
                3'b110: begin d = in_word; lat = io_delay + 2; end
                3'b111: lat = io_delay + 2;
                default: begin model_err = 1'b1; lat = 2; end
            endcase
        end
        if (is_mem) begin
            maddr = {rgn, addr};
            key = int'(maddr);
            if (we) ref_mem[key] = wd;
            else d = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_err = 1'b0;
        model_last_host = 1'b1;
    endtask

    // Driver: issue one request, then follow it to its response with checks.
    task automatic run_txn(input string tag, input bit is_host, input logic [2:0] op, input bit hw,
                           input bit hr, input logic [15:0] addr, input logic [7:0] wd,
                           input int io_delay, input logic [7:0] in_word, input logic [7:0] exp_d,
                           input int exp_lat, input bit exp_mem, input logic [16:0] exp_maddr,
                           input bit exp_we);
        int  k;
        bit  got;
        bit  seen;
        bit  rv;
        if (is_host) begin
            bus.host_req_valid = 1'b1; bus.host_req_write = hw; bus.host_req_region = hr;
            bus.host_req_addr = addr; bus.host_req_wdata = wd;
        end else begin
            bus.core_req_valid = 1'b1; bus.core_req_op = op;
            bus.core_req_addr = addr; bus.core_req_wdata = wd;
        end
        #1;
        k = 0;
        while (!(is_host ? bus.host_req_ready : bus.core_req_ready) && k < 8) begin
            @(negedge clock);
            #1;
            k++;
        end
        got = is_host ? bus.host_req_ready : bus.core_req_ready;
        chk({tag, " ready"}, 32'(got), 32'd1);
        if (!got) begin
            bus.host_req_valid = 1'b0; bus.core_req_valid = 1'b0;
            return;
        end
        chk({tag, " other_ready"}, 32'(is_host ? bus.core_req_ready : bus.host_req_ready), 32'd0);
        @(negedge clock);
        bus.host_req_valid = 1'b0; bus.core_req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= exp_lat + 2 && !seen; c++) begin
            if (c > 1) @(negedge clock);
            if (!is_host && op == 3'b111) bus.out_ready = (c > io_delay);
            if (!is_host && op == 3'b110) begin
                bus.in_valid = (c > io_delay);
                bus.in_data = in_word;
            end
            #1;
            if (c == 1) begin
                chk({tag, " mem_en"}, 32'(bus.mem_en), 32'(exp_mem));
                if (exp_mem) begin
                    chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(exp_maddr));
                    chk({tag, " mem_we"}, 32'(bus.mem_we), 32'(exp_we));
                end
            end
            if (!is_host && op == 3'b111 && c <= io_delay + 1) begin
                chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
                chk({tag, " out_data"}, 32'(bus.out_data), 32'(wd));
            end
            if (!is_host && op == 3'b110 && c <= io_delay + 1)
                chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
            chk({tag, " other_resp"}, 32'(is_host ? bus.core_resp_valid : bus.host_resp_valid), 32'd0);
            rv = is_host ? bus.host_resp_valid : bus.core_resp_valid;
            if (rv) begin
                seen = 1'b1;
                chk({tag, " latency"}, 32'(c), 32'(exp_lat));
                chk({tag, " resp_data"}, 32'(is_host ? bus.host_resp_data : bus.core_resp_data), 32'(exp_d));
            end
        end
        chk({tag, " resp_seen"}, 32'(seen), 32'd1);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clock);
        #1;
        chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
        chk({tag, " resp_one_cycle"}, 32'(is_host ? bus.host_resp_valid : bus.core_resp_valid), 32'd0);
    endtask

    // Both requesters valid at every IDLE for four transactions.
    task automatic tie_test();
        logic [7:0]  d;
        int          lat;
        bit          ism;
        bit          we;
        logic [16:0] ma;
        bit          pred;
        for (int i = 0; i < 4; i++) begin
`ifdef BF_ARB_ROUND_ROBIN_EN
            pred = !model_last_host;
`else
            pred = 1'b1;
`endif
            bus.core_req_valid = 1'b1; bus.core_req_op = 3'b100;
            bus.core_req_addr = 16'h0007; bus.core_req_wdata = 8'h00;
            bus.host_req_valid = 1'b1; bus.host_req_write = 1'b0; bus.host_req_region = 1'b1;
            bus.host_req_addr = 16'h0008; bus.host_req_wdata = 8'h00;
            #1;
            chk("tie core_ready", 32'(bus.core_req_ready), 32'(!pred));
            chk("tie host_ready", 32'(bus.host_req_ready), 32'(pred));
            if (pred) model_txn(1'b1, 3'b000, 1'b0, 1'b1, 16'h0008, 8'h00, 8'h00, 0, d, lat, ism, ma, we);
            else      model_txn(1'b0, 3'b100, 1'b0, 1'b0, 16'h0007, 8'h00, 8'h00, 0, d, lat, ism, ma, we);
            @(negedge clock);
            if (pred) bus.host_req_valid = 1'b0;
            else      bus.core_req_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                if (c > 1) @(negedge clock);
                #1;
                chk("tie loser_ready", 32'(pred ? bus.core_req_ready : bus.host_req_ready), 32'd0);
                chk("tie resp_valid", 32'(pred ? bus.host_resp_valid : bus.core_resp_valid), 32'(c == 3));
                if (c == 3)
                    chk("tie resp_data", 32'(pred ? bus.host_resp_data : bus.core_resp_data), 32'(d));
            end
            @(negedge clock);
        end
        bus.core_req_valid = 1'b0;
        bus.host_req_valid = 1'b0;
    endtask

    typedef struct {
        bit          is_host;
        logic [2:0]  op;
        bit          hw;
        bit          hr;
        logic [15:0] addr;
        logic [7:0]  wd;
        int          io_delay;
        logic [7:0]  in_word;
        logic [7:0]  exp_d;
        int          exp_lat;
        bit          exp_mem;
        logic [16:0] exp_maddr;
        bit          exp_we;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic [7:0]  d;
        int          lat;
        bit          ism;
        bit          we;
        logic [16:0] ma;
        bit          is_host;
        logic [2:0]  op;
        bit          hw;
        bit          hr;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  iw;
        int          dly;

        //        host op      hw hr addr      wd     dly in     exp    lat mem maddr      we
        vt[0] = '{1, 3'b000, 1, 1, 16'h0005, 8'h2A, 0, 8'h00, 8'h00, 3, 1, 17'h10005, 1};
        vt[1] = '{0, 3'b100, 0, 0, 16'h0005, 8'h00, 0, 8'h00, 8'h2A, 3, 1, 17'h10005, 0};
        vt[2] = '{1, 3'b000, 1, 0, 16'h0003, 8'h2B, 0, 8'h00, 8'h00, 3, 1, 17'h00003, 1};
        vt[3] = '{0, 3'b010, 0, 0, 16'h0003, 8'h00, 0, 8'h00, 8'h2B, 3, 1, 17'h00003, 0};
        vt[4] = '{0, 3'b111, 0, 0, 16'h0000, 8'h41, 5, 8'h00, 8'h00, 7, 0, 17'h00000, 0};
        vt[5] = '{0, 3'b110, 0, 0, 16'h0000, 8'h00, 2, 8'h5A, 8'h5A, 4, 0, 17'h00000, 0};
        vt[6] = '{0, 3'b101, 0, 0, 16'h1234, 8'h77, 0, 8'h00, 8'h00, 3, 1, 17'h11234, 1};
        vt[7] = '{1, 3'b000, 0, 1, 16'h1234, 8'h00, 0, 8'h00, 8'h77, 3, 1, 17'h11234, 0};
        vt[8] = '{0, 3'b001, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 8'h00, 2, 0, 17'h00000, 0};

        for (int i = 0; i < 131072; i++) sram[i] = 8'h00;
        bus.core_req_valid = 1'b0; bus.core_req_op = 3'b000;
        bus.core_req_addr = '0; bus.core_req_wdata = '0;
        bus.host_req_valid = 1'b0; bus.host_req_write = 1'b0; bus.host_req_region = 1'b0;
        bus.host_req_addr = '0; bus.host_req_wdata = '0;
        bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
        model_err = 1'b0;
        model_last_host = 1'b1;

        @(negedge clock);
        do_reset();
        #1;
        chk("rst core_ready", 32'(bus.core_req_ready), 32'd0);
        chk("rst host_ready", 32'(bus.host_req_ready), 32'd0);
        chk("rst core_resp", 32'(bus.core_resp_valid), 32'd0);
        chk("rst host_resp", 32'(bus.host_resp_valid), 32'd0);
        chk("rst mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data", 32'(bus.out_data), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        chk("rst fsm_state", 32'(bus.fsm_state), 32'd0);

        tie_test();

        for (int i = 0; i < 9; i++) begin
            model_txn(vt[i].is_host, vt[i].op, vt[i].hw, vt[i].hr, vt[i].addr, vt[i].wd,
                      vt[i].in_word, vt[i].io_delay, d, lat, ism, ma, we);
            run_txn($sformatf("vec%0d", i), vt[i].is_host, vt[i].op, vt[i].hw, vt[i].hr,
                    vt[i].addr, vt[i].wd, vt[i].io_delay, vt[i].in_word, vt[i].exp_d,
                    vt[i].exp_lat, vt[i].exp_mem, vt[i].exp_maddr, vt[i].exp_we);
        end

        // Sticky error survives later traffic and clears only on reset.
        chk("err set", 32'(bus.err), 32'd1);
        model_txn(1'b1, 3'b000, 1'b0, 1'b1, 16'h0005, 8'h00, 8'h00, 0, d, lat, ism, ma, we);
        run_txn("err_hold_txn", 1'b1, 3'b000, 1'b0, 1'b1, 16'h0005, 8'h00, 0, 8'h00,
                8'h2A, 3, 1'b1, 17'h10005, 1'b0);
        chk("err held", 32'(bus.err), 32'd1);
        do_reset();
        #1;
        chk("err cleared", 32'(bus.err), 32'd0);

        // Reset while waiting in IN: no response, later input word not consumed.
        @(negedge clock);
        bus.core_req_valid = 1'b1; bus.core_req_op = 3'b110;
        bus.core_req_addr = '0; bus.core_req_wdata = '0;
        #1;
        chk("rstin ready", 32'(bus.core_req_ready), 32'd1);
        @(negedge clock);
        bus.core_req_valid = 1'b0;
        #1;
        chk("rstin in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        do_reset();
        #1;
        chk("rstin in_ready_off", 32'(bus.in_ready), 32'd0);
        chk("rstin busy", 32'(bus.busy), 32'd0);
        chk("rstin resp", 32'(bus.core_resp_valid), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h99;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            chk("rstin no_consume", 32'(bus.in_ready), 32'd0);
            chk("rstin no_resp", 32'(bus.core_resp_valid), 32'd0);
        end
        bus.in_valid = 1'b0;
        @(negedge clock);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            is_host = 1'($urandom_range(0, 1));
            op      = 3'($urandom_range(0, 7));
            hw      = 1'($urandom_range(0, 1));
            hr      = 1'($urandom_range(0, 1));
            addr    = 16'($urandom_range(0, 15));
            wd      = 8'($urandom_range(0, 255));
            iw      = 8'($urandom_range(0, 255));
            dly     = int'($urandom_range(0, 3));
            model_txn(is_host, op, hw, hr, addr, wd, iw, dly, d, lat, ism, ma, we);
            run_txn($sformatf("rnd%0d", i), is_host, op, hw, hr, addr, wd, dly, iw,
                    d, lat, ism, ma, we);
        end
        chk("rnd err", 32'(bus.err), 32'(model_err));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
